// File: rtl/mc_control_unit_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller takes the slave view; the datapath (or a bench) takes the master view.
interface mc_control_unit_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       Branch;
  logic       PCEn;
  logic [1:0] PCSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic [3:0] State;

  modport slave (
    input  Op, Funct, Zero,
    output IorD, MemWrite, IRWrite, PCWrite, Branch, PCEn, PCSrc,
           ALUSrcA, ALUSrcB, ALUControl, RegDst, MemtoReg, RegWrite, State
  );

  modport master (
    output Op, Funct, Zero,
    input  IorD, MemWrite, IRWrite, PCWrite, Branch, PCEn, PCSrc,
           ALUSrcA, ALUSrcB, ALUControl, RegDst, MemtoReg, RegWrite, State
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle MIPS main controller: Moore sequencing FSM plus ALU decoder.
// All outputs are forced to 0 while RST_N is low so no write can escape during reset.
module mc_control_unit (
  input  logic               CLK,
  input  logic               RST_N,
  mc_control_unit_if.slave   bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_aluop;
  logic       w_alu_en;
  logic       w_funct_ok;
  logic [2:0] w_alu_ctl;
  logic       w_iord, w_memwrite, w_irwrite, w_pcwrite, w_branch;
  logic [1:0] w_pcsrc, w_alusrcb;
  logic       w_alusrca, w_regdst, w_memtoreg, w_regwrite;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    case (bus.Funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: w_funct_ok = 1'b1;
      default:                                              w_funct_ok = 1'b0;
    endcase
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next     = FETCH;
    w_aluop    = 2'b00;
    w_alu_en   = 1'b1;
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_pcsrc    = 2'b00;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    case (r_state)
      FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        w_alusrcb = 2'b01;
        w_next    = DECODE;
      end
      DECODE: begin
        w_alusrcb = 2'b11;
        case (bus.Op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYP:      w_next = w_funct_ok ? EXECUTE : FETCH;
          OP_BEQ:       w_next = BRANCH;
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JUMP;
          default:      w_next = FETCH;
        endcase
      end
      MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (bus.Op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        w_iord = 1'b1;
        w_next = MEMWB;
      end
      MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        w_next    = ALUWB;
      end
      ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      BRANCH: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b01;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
      end
      ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = ADDIWB;
      end
      ADDIWB: w_regwrite = 1'b1;
      JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
      end
      // Encodings 12-15 drive nothing, including the ALU code, and recover to FETCH.
      default: w_alu_en = 1'b0;
    endcase
  end

  always_comb begin
    w_alu_ctl = 3'b010;
    case (w_aluop)
      2'b00: w_alu_ctl = 3'b010;
      2'b01: w_alu_ctl = 3'b110;
      default: begin
        case (bus.Funct)
          6'b100010: w_alu_ctl = 3'b110;
          6'b100100: w_alu_ctl = 3'b000;
          6'b100101: w_alu_ctl = 3'b001;
          6'b101010: w_alu_ctl = 3'b111;
          default:   w_alu_ctl = 3'b010;
        endcase
      end
    endcase
    if (!w_alu_en) w_alu_ctl = 3'b000;
  end

  assign bus.IorD       = RST_N ? w_iord     : 1'b0;
  assign bus.MemWrite   = RST_N ? w_memwrite : 1'b0;
  assign bus.IRWrite    = RST_N ? w_irwrite  : 1'b0;
  assign bus.PCWrite    = RST_N ? w_pcwrite  : 1'b0;
  assign bus.Branch     = RST_N ? w_branch   : 1'b0;
  assign bus.PCEn       = RST_N ? (w_pcwrite | (w_branch & bus.Zero)) : 1'b0;
  assign bus.PCSrc      = RST_N ? w_pcsrc    : 2'b00;
  assign bus.ALUSrcA    = RST_N ? w_alusrca  : 1'b0;
  assign bus.ALUSrcB    = RST_N ? w_alusrcb  : 2'b00;
  assign bus.ALUControl = RST_N ? w_alu_ctl  : 3'b000;
  assign bus.RegDst     = RST_N ? w_regdst   : 1'b0;
  assign bus.MemtoReg   = RST_N ? w_memtoreg : 1'b0;
  assign bus.RegWrite   = RST_N ? w_regwrite : 1'b0;
  assign bus.State      = RST_N ? r_state    : 4'd0;

endmodule
